// File: rtl/instr_encoder.sv
// Instruction encoder: turns op/field requests into 32-bit MIPS-style words,
// queues them in a small FIFO and streams them to instruction memory.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              prog_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W:0]   word_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic op_legal(input logic [3:0] sel);
    return sel <= 4'd13;
  endfunction

  function automatic logic [31:0] encode(input logic [3:0]  sel,
                                         input logic [4:0]  s,
                                         input logic [4:0]  t,
                                         input logic [4:0]  d,
                                         input logic [15:0] i,
                                         input logic [25:0] tg);
    logic [31:0] w;
    w = '0;
    case (sel)
      4'd0:    w = {6'b000000, s, t, d, 5'b00000, 6'b100000};
      4'd1:    w = {6'b000000, s, t, d, 5'b00000, 6'b100010};
      4'd2:    w = {6'b000000, s, t, d, 5'b00000, 6'b100100};
      4'd3:    w = {6'b000000, s, t, d, 5'b00000, 6'b100101};
      4'd4:    w = {6'b000000, s, t, d, 5'b00000, 6'b101010};
      4'd5:    w = {6'b000001, s, t, i};
      4'd6:    w = {6'b000010, s, t, i};
      4'd7:    w = {6'b000011, s, t, i};
      4'd8:    w = {6'b000100, s, t, i};
      4'd9:    w = {6'b000101, s, t, i};
      4'd10:   w = {6'b000110, s, t, i};
      4'd11:   w = {6'b000111, s, t, i};
      4'd12:   w = {6'b001000, s, t, i};
      4'd13:   w = {6'b001001, tg};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (&v) ? v : v + (ADDR_W+1)'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  state_t            state, state_nx;
  logic [31:0]       fifo_p1 [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       word_p0;
  logic              vld_p0;
  logic              full, empty, accept, pop, start;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = (state == RUN) && !full;
  assign accept   = in_valid && in_ready;
  assign pop      = !empty && mem_ready;
  assign start    = (state == IDLE) && prog_start;

  // stage p0: encode the request in the accept cycle
  assign word_p0 = encode(op_sel, rs, rt, rd, imm, target);
  assign vld_p0  = accept && op_legal(op_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE:  if (prog_start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (finish) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (empty) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // stage p1: FIFO; only the pointers and occupancy are reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (vld_p0) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({vld_p0, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) fifo_p1[wr_ptr] <= word_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      word_count <= '0;
      err        <= 1'b0;
    end else if (start) begin
      addr_q     <= base_addr;
      word_count <= '0;
      err        <= 1'b0;
    end else begin
      if (pop) begin
        addr_q     <= addr_q + ADDR_W'(1);
        word_count <= sat_inc(word_count);
      end
      if (accept && !op_legal(op_sel)) err <= 1'b1;
    end
  end

  // stage p2: memory write port, head word gated so an empty FIFO drives zero
  assign mem_we    = !empty;
  assign mem_addr  = addr_q;
  assign mem_wdata = empty ? '0 : fifo_p1[rd_ptr];

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder with a queue-based reference model and
// directed scenarios pinning the encodings, stall, wrap, done and reset.
module tb_instr_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int WC_MAX = (1 << (ADDR_W + 1)) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        op_sel = '0;
  logic [4:0]        rs = '0, rt = '0, rd = '0;
  logic [15:0]       imm = '0;
  logic [25:0]       target = '0;
  logic              prog_start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              finish = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready = 1'b0;
  logic              done, err, busy;
  logic [ADDR_W:0]   word_count;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .prog_start(prog_start), .base_addr(base_addr), .finish(finish),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .done(done), .err(err), .busy(busy),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog expired before the run completed");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding straight from the opcode/funct tables
  int unsigned opc_tab [16] = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0};
  int unsigned fn_tab  [5]  = '{32, 34, 36, 37, 42};

  function automatic logic [31:0] ref_encode(input int unsigned op, input int unsigned s,
                                             input int unsigned t, input int unsigned d,
                                             input int unsigned i, input int unsigned tg);
    int unsigned w;
    if (op < 5)        w = (s << 21) | (t << 16) | (d << 11) | fn_tab[op];
    else if (op == 13) w = (opc_tab[op] << 26) | tg;
    else               w = (opc_tab[op] << 26) | (s << 21) | (t << 16) | i;
    return w;
  endfunction

  // Behavioural model: phase 0 idle, 1 run, 2 drain, 3 done
  int unsigned       q [$];
  int                mph = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  int                m_wc = 0;
  logic              m_err = 1'b0;
  bit                m_rdy, m_we;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mph = 0; m_addr = '0; m_wc = 0; m_err = 1'b0;
    end else begin
      m_rdy = (mph == 1) && (q.size() < DEPTH);
      m_we  = (q.size() != 0);
      if (m_we && mem_ready) begin
        void'(q.pop_front());
        m_addr = m_addr + 1'b1;
        if (m_wc < WC_MAX) m_wc++;
      end
      if (in_valid && m_rdy) begin
        if (op_sel > 4'd13) m_err = 1'b1;
        else q.push_back(ref_encode(op_sel, rs, rt, rd, imm, target));
      end
      case (mph)
        0: if (prog_start) begin mph = 1; m_addr = base_addr; m_wc = 0; m_err = 1'b0; end
        1: if (finish) mph = 2;
        2: if (!m_we) mph = 3;
        default: mph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, (mph == 1) && (q.size() < DEPTH));
    chk("mem_we", mem_we, q.size() != 0);
    chk("mem_addr", mem_addr, m_addr);
    if (q.size() != 0) chk("mem_wdata", mem_wdata, q[0]);
    else if (!rst_n)   chk("mem_wdata_rst", mem_wdata, 0);
    chk("done", done, mph == 3);
    chk("err", err, m_err);
    chk("busy", busy, (mph == 1) || (mph == 2));
    chk("word_count", word_count, m_wc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input int s, input int t, input int d,
                       input int i, input int tg);
    in_valid = 1'b1;
    op_sel = 4'(op); rs = 5'(s); rt = 5'(t); rd = 5'(d);
    imm = 16'(i); target = 26'(tg);
  endtask

  task automatic count_done(input string name);
    int pulses;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      #1;
      if (done) pulses++;
    end
    chk(name, pulses, 1);
  endtask

  logic [31:0] exp_w [4];
  bit          did_rst;
  int          n;

  initial begin
    // reset values
    tick(); tick(); #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_count", word_count, 0);
    rst_n = 1'b1;

    // addi at base 0x10
    tick();
    prog_start = 1'b1; base_addr = 8'h10;
    tick();
    prog_start = 1'b0;
    chk("s1_busy", busy, 1);
    drive(7, 1, 2, 0, 5, 0); mem_ready = 1'b1;
    tick();
    in_valid = 1'b0; #2;
    chk("s1_we", mem_we, 1);
    chk("s1_addr", mem_addr, 8'h10);
    chk("s1_data", mem_wdata, 32'h0C220005);
    chk("s1_wc0", word_count, 0);
    tick(); #2;
    chk("s1_wc1", word_count, 1);
    chk("s1_we_off", mem_we, 0);

    // add then j to consecutive addresses
    drive(0, 3, 4, 5, 0, 0);
    tick();
    drive(13, 0, 0, 0, 0, 26'h10); #2;
    chk("s2_add", mem_wdata, 32'h00642820);
    chk("s2_add_addr", mem_addr, 8'h11);
    tick();
    in_valid = 1'b0; #2;
    chk("s2_j", mem_wdata, 32'h24000010);
    chk("s2_j_addr", mem_addr, 8'h12);
    tick(); #2;
    chk("s2_wc", word_count, 3);

    // stall with a full FIFO, then drain in order
    mem_ready = 1'b0;
    exp_w[0] = ref_encode(1, 1, 2, 3, 0, 0);
    exp_w[1] = ref_encode(2, 4, 5, 6, 0, 0);
    exp_w[2] = ref_encode(3, 7, 8, 9, 0, 0);
    exp_w[3] = ref_encode(4, 10, 11, 12, 0, 0);
    chk("s3_sub_literal", exp_w[0], 32'h00221822);
    for (int k = 0; k < 4; k++) begin
      drive(k + 1, 3 * k + 1, 3 * k + 2, 3 * k + 3, 0, 0);
      tick();
    end
    in_valid = 1'b0; #2;
    chk("s3_full_ready", in_ready, 0);
    chk("s3_head", mem_wdata, 32'h00221822);
    tick(); tick(); #2;
    chk("s3_hold_data", mem_wdata, 32'h00221822);
    chk("s3_hold_addr", mem_addr, 8'h13);
    chk("s3_hold_wc", word_count, 3);
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("s3_order", mem_wdata, exp_w[k]);
      chk("s3_addr", mem_addr, 8'h13 + 8'(k));
      tick(); #2;
    end
    chk("s3_wc", word_count, 7);

    // illegal op
    drive(14, 1, 1, 1, 1, 1); #1;
    chk("s4_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; #2;
    chk("s4_err", err, 1);
    chk("s4_no_write", mem_we, 0);
    chk("s4_wc", word_count, 7);
    tick(); tick(); #2;
    chk("s4_err_sticky", err, 1);
    finish = 1'b1;
    tick();
    finish = 1'b0; #2;
    chk("s4_drain_ready", in_ready, 0);
    count_done("s4_done_pulses");
    chk("s4_idle_busy", busy, 0);

    // address wrap from 0xFF
    prog_start = 1'b1; base_addr = 8'hFF;
    tick();
    prog_start = 1'b0; #2;
    chk("s5_err_clr", err, 0);
    drive(0, 1, 1, 1, 0, 0);
    tick();
    drive(0, 2, 2, 2, 0, 0); #2;
    chk("s5_addr_ff", mem_addr, 8'hFF);
    tick();
    in_valid = 1'b0; #2;
    chk("s5_addr_00", mem_addr, 8'h00);
    chk("s5_we", mem_we, 1);
    tick(); #2;
    chk("s5_wc", word_count, 2);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    count_done("s5_done_pulses");

    // reset during DRAIN with 3 pending words
    prog_start = 1'b1; base_addr = 8'h40;
    tick();
    prog_start = 1'b0; mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(7, k, k, 0, k + 100, 0);
      tick();
    end
    in_valid = 1'b0; finish = 1'b1;
    tick();
    finish = 1'b0; #2;
    chk("s6_drain_busy", busy, 1);
    chk("s6_pending", mem_we, 1);
    rst_n = 1'b0; #1;
    chk("s6_rst_we", mem_we, 0);
    chk("s6_rst_ready", in_ready, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_addr", mem_addr, 0);
    mem_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); #2;
      chk("s6_after_we", mem_we, 0);
      chk("s6_after_busy", busy, 0);
    end

    // randomized programs
    for (int p = 0; p < 30; p++) begin
      int len;
      did_rst = 1'b0;
      prog_start = 1'b1; base_addr = 8'($urandom);
      tick();
      prog_start = 1'b0;
      len = $urandom_range(5, 60);
      for (int c = 0; c < len; c++) begin
        in_valid = ($urandom % 4) != 0;
        op_sel = 4'($urandom_range(0, 15));
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        imm = 16'($urandom); target = 26'($urandom);
        mem_ready = ($urandom % 3) != 0;
        prog_start = ($urandom % 8) == 0;
        base_addr = 8'($urandom);
        if ((p % 7) == 3 && c == len / 2) begin
          rst_n = 1'b0; did_rst = 1'b1;
        end else begin
          rst_n = 1'b1;
        end
        tick();
      end
      rst_n = 1'b1; in_valid = 1'b0; prog_start = 1'b0;
      if (!did_rst) begin
        finish = 1'b1;
        tick();
        finish = 1'b0;
        n = 0;
        while (!done && n < 100) begin
          mem_ready = ($urandom % 2) != 0;
          tick();
          n++;
        end
        chk("rand_done_seen", done, 1);
      end
      tick();
    end

    // long program to exercise word_count saturation
    prog_start = 1'b1; base_addr = 8'($urandom);
    tick();
    prog_start = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 13), $urandom, $urandom, $urandom, $urandom, $urandom);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); #2;
    chk("sat_wc", word_count, WC_MAX);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    count_done("sat_done_pulses");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
